// File: rtl/line_clear_engine_if.sv
// Handshake/data bundle between the line-clear engine and its clients.
//   start         : single-cycle request from the game FSM
//   field_in      : locked-in field snapshot (bit i = row i/COLS, col i%COLS, row 0 = top)
//   busy          : engine is working on a request (SCAN and DONE)
//   done          : one-cycle pulse, results valid from this cycle
//   field_out     : collapsed field, same indexing as field_in
//   lines_cleared : number of full rows removed
//   score_delta   : score increment for this clear
// master = requester side, slave = engine side.
interface line_clear_engine_if #(
    parameter int COLS    = 20,
    parameter int ROWS    = 20,
    parameter int SCORE_W = 16
);
    localparam int CNT_W = $clog2(ROWS + 1);

    logic                   start;
    logic [0:ROWS*COLS-1]   field_in;
    logic                   busy;
    logic                   done;
    logic [0:ROWS*COLS-1]   field_out;
    logic [CNT_W-1:0]       lines_cleared;
    logic [SCORE_W-1:0]     score_delta;

    modport master (
        output start, field_in,
        input  busy, done, field_out, lines_cleared, score_delta
    );

    modport slave (
        input  start, field_in,
        output busy, done, field_out, lines_cleared, score_delta
    );
endinterface

// File: rtl/line_clear_engine.sv
// Sequential line-clear engine for the playfield.
// Scans the working copy of the field bottom-to-top, one row per cycle.
// A full row is removed by dropping every row above it by one and feeding
// an empty row in at the top; the same row index is then re-examined.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; aborts any scan in progress
//   bus   : line_clear_engine_if.slave (start/field_in in, busy/done/results out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SCAN  | examining working row `row`, collapsing full rows
// DONE  | one-cycle done pulse, results registered on entry
module line_clear_engine #(
    parameter int COLS       = 20,
    parameter int ROWS       = 20,
    parameter int SCORE_W    = 16,
    parameter int SCORE_1    = 40,
    parameter int SCORE_2    = 100,
    parameter int SCORE_3    = 300,
    parameter int SCORE_4    = 1200,
    parameter int EARLY_EXIT = 0
) (
    input  logic               clk,
    input  logic               reset,
    line_clear_engine_if.slave bus
);
    localparam int CNT_W = $clog2(ROWS + 1);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state;
    logic [COLS-1:0]   work    [ROWS];
    logic [COLS-1:0]   dropped [ROWS];
    logic [ROW_W-1:0]  row;
    logic [CNT_W-1:0]  cnt;
    logic              cur_full;
    logic              cur_empty;
    logic              scan_end;

    assign cur_full  = &work[row];
    assign cur_empty = ~|work[row];
    // Empty-row exit takes priority; otherwise the scan ends once row 0 is not full.
    assign scan_end  = ((EARLY_EXIT != 0) && cur_empty) || (!cur_full && (row == '0));

    // Working field with the current row removed: rows 1..row take the row
    // above them, row 0 becomes empty, rows below `row` are untouched.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            dropped[r] = work[r];
            if (r == 0) begin
                dropped[r] = '0;
            end else if (r <= int'(row)) begin
                dropped[r] = work[r-1];
            end
        end
    end

    function automatic logic [SCORE_W-1:0] score_of(input logic [CNT_W-1:0] c);
        logic [SCORE_W-1:0] s;
        s = '0;
        if (int'(c) == 1)      s = SCORE_W'(SCORE_1);
        else if (int'(c) == 2) s = SCORE_W'(SCORE_2);
        else if (int'(c) == 3) s = SCORE_W'(SCORE_3);
        else if (int'(c) >= 4) s = SCORE_W'(SCORE_4);
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            row               <= '0;
            cnt               <= '0;
            for (int r = 0; r < ROWS; r++) work[r] <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.field_out     <= '0;
            bus.lines_cleared <= '0;
            bus.score_delta   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int r = 0; r < ROWS; r++) begin
                            work[r] <= bus.field_in[r*COLS +: COLS];
                        end
                        row      <= ROW_W'(ROWS - 1);
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_end) begin
                        for (int r = 0; r < ROWS; r++) begin
                            bus.field_out[r*COLS +: COLS] <= work[r];
                        end
                        bus.lines_cleared <= cnt;
                        bus.score_delta   <= score_of(cnt);
                        bus.done          <= 1'b1;
                        state             <= DONE;
                    end else if (cur_full) begin
                        for (int r = 0; r < ROWS; r++) work[r] <= dropped[r];
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        row <= row - ROW_W'(1);
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: 20x20, 4x4 and 20x20 early-exit builds
// share one clock and reset. Latency is counted in rising edges starting with
// the edge that samples start (an empty 20-row scan gives 21).
module tb_line_clear_engine;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   lat;
    int   ndone;

    always #5 clk = ~clk;

    line_clear_engine_if #(.COLS(20), .ROWS(20), .SCORE_W(16)) i20 ();
    line_clear_engine_if #(.COLS(4),  .ROWS(4),  .SCORE_W(16)) i4  ();
    line_clear_engine_if #(.COLS(20), .ROWS(20), .SCORE_W(16)) ie  ();

    line_clear_engine #(.COLS(20), .ROWS(20), .EARLY_EXIT(0)) u20 (.clk(clk), .reset(reset), .bus(i20));
    line_clear_engine #(.COLS(4),  .ROWS(4),  .EARLY_EXIT(0)) u4  (.clk(clk), .reset(reset), .bus(i4));
    line_clear_engine #(.COLS(20), .ROWS(20), .EARLY_EXIT(1)) ue  (.clk(clk), .reset(reset), .bus(ie));

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run20(input string tag, input logic [0:399] f, input logic [0:399] ef,
                         input int el, input int es, input int elat);
        i20.field_in = f;
        i20.start    = 1'b1;
        @(posedge clk); #1;
        i20.start = 1'b0;
        lat = 1;
        chk({tag, "/busy"}, 400'(i20.busy), 400'(1));
        while (i20.done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/lat"},   400'(lat), 400'(elat));
        chk({tag, "/field"}, i20.field_out, ef);
        chk({tag, "/lines"}, 400'(i20.lines_cleared), 400'(el));
        chk({tag, "/score"}, 400'(i20.score_delta), 400'(es));
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, 400'({i20.done, i20.busy}), 400'(0));
        chk({tag, "/hold"}, i20.field_out, ef);
    endtask

    task automatic run4(input string tag, input logic [0:15] f, input logic [0:15] ef,
                        input int el, input int es, input int elat, input int pulse_at);
        i4.field_in = f;
        i4.start    = 1'b1;
        @(posedge clk); #1;
        i4.start = 1'b0;
        lat = 1;
        while (i4.done !== 1'b1 && lat < 200) begin
            if (lat == pulse_at) begin
                i4.start    = 1'b1;
                i4.field_in = '0;
            end
            @(posedge clk); #1;
            i4.start = 1'b0;
            lat++;
        end
        chk({tag, "/lat"},   400'(lat), 400'(elat));
        chk({tag, "/field"}, 400'(i4.field_out), 400'(ef));
        chk({tag, "/lines"}, 400'(i4.lines_cleared), 400'(el));
        chk({tag, "/score"}, 400'(i4.score_delta), 400'(es));
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, 400'({i4.done, i4.busy}), 400'(0));
    endtask

    task automatic rune(input string tag, input logic [0:399] f, input logic [0:399] ef,
                        input int el, input int es, input int elat);
        ie.field_in = f;
        ie.start    = 1'b1;
        @(posedge clk); #1;
        ie.start = 1'b0;
        lat = 1;
        while (ie.done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/lat"},   400'(lat), 400'(elat));
        chk({tag, "/field"}, ie.field_out, ef);
        chk({tag, "/lines"}, 400'(ie.lines_cleared), 400'(el));
        chk({tag, "/score"}, 400'(ie.score_delta), 400'(es));
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, 400'({ie.done, ie.busy}), 400'(0));
    endtask

    initial begin
        logic [0:399] f;
        logic [0:399] ef;

        reset = 1'b1;
        i20.start = 1'b0; i20.field_in = '0;
        i4.start  = 1'b0; i4.field_in  = '0;
        ie.start  = 1'b0; ie.field_in  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst20", {i20.field_out}, '0);
        chk("rst20_misc", 400'({i20.busy, i20.done, i20.lines_cleared, i20.score_delta}), 400'(0));
        chk("rst4", 400'({i4.busy, i4.done, i4.field_out, i4.lines_cleared, i4.score_delta}), 400'(0));
        chk("rste", 400'({ie.busy, ie.done, ie.lines_cleared, ie.score_delta}), 400'(0));

        // Empty field: full scan, nothing cleared.
        run20("z20", '0, '0, 0, 0, 21);

        // Bottom row full plus top-left cell: the cell drops to row 1 col 0.
        f = '0;
        for (int i = 380; i < 400; i++) f[i] = 1'b1;
        f[0] = 1'b1;
        ef = '0; ef[20] = 1'b1;
        run20("one20", f, ef, 1, 40, 22);

        // Rows 16..19 full, one cell at row 15 col 3 lands at row 19 col 3.
        f = '0;
        for (int i = 320; i < 400; i++) f[i] = 1'b1;
        f[303] = 1'b1;
        ef = '0; ef[383] = 1'b1;
        run20("four20", f, ef, 4, 1200, 25);

        // Full rows 15, 17, 19; cells at row 18 col 5 and row 16 col 7.
        f = '0;
        for (int c = 0; c < 20; c++) begin
            f[15*20 + c] = 1'b1;
            f[17*20 + c] = 1'b1;
            f[19*20 + c] = 1'b1;
        end
        f[18*20 + 5] = 1'b1;
        f[16*20 + 7] = 1'b1;
        ef = '0; ef[19*20 + 5] = 1'b1; ef[18*20 + 7] = 1'b1;
        run20("three20", f, ef, 3, 300, 24);

        // 4x4: rows 1 and 3 full, row 2 = 0101, row 0 = 1000 (leftmost digit = col 0).
        run4("mix4", 16'b1000_1111_0101_1111, 16'b0000_0000_1000_0101, 2, 100, 7, 0);

        // 4x4 all ones, with an extra start (empty field) pulsed mid-scan.
        run4("ones4", 16'hFFFF, 16'h0000, 4, 1200, 9, 3);

        // Reset mid-scan after a non-zero result is held: no done, outputs cleared.
        run4("pre4", 16'b1111_0000_0000_1111, 16'b0000_0000_0000_0000, 2, 100, 7, 0);
        i4.field_in = 16'hFFFF;
        i4.start    = 1'b1;
        @(posedge clk); #1;
        i4.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy_done", 400'({i4.busy, i4.done}), 400'(0));
        chk("midrst_outputs", 400'({i4.field_out, i4.lines_cleared, i4.score_delta}), 400'(0));
        ndone = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (i4.done === 1'b1) ndone++;
        end
        chk("midrst_no_done", 400'(ndone), 400'(0));

        // Early exit: empty field finishes on the first row examined.
        rune("ez", '0, '0, 0, 0, 2);

        // Early exit: row 19 full, rest empty.
        f = '0;
        for (int i = 380; i < 400; i++) f[i] = 1'b1;
        rune("eone", f, '0, 1, 40, 3);

        // Early exit: empty bottom row hides a full top row.
        f = '0;
        for (int i = 0; i < 20; i++) f[i] = 1'b1;
        rune("ehide", f, f, 0, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
